// File: rtl/decode_ex_stage_reg.sv
// ID/EX pipeline stage register for the RV32I core.
// Sits between decode (register file read) and execute. Registers operands and
// decoded control, forwards the write-back result across the register file's
// write-then-read gap, inserts one bubble on a load-use hazard, supports
// valid/ready back-pressure (refreshing held operands from write-back), flush,
// and counts inserted interlock bubbles with a saturating counter.
//
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   id_valid / id_ready             decode handshake (id_ready combinational)
//   id_pc, id_rs1/2, id_rd,
//   id_rd1/2, id_imm, id_alu_op,
//   id_alu_src, id_mem_read,
//   id_mem_write, id_reg_wr,
//   id_mem_to_reg                   decoded instruction fields
//   wb_reg_wr, wb_rd, wb_data       write-back port (bypass source)
//   ex_ready                        execute stage consumes ex_* this cycle
//   flush                           kill contents on redirect
//   ex_*                            registered instruction presented to execute
//   load_use_stall                  interlock active (combinational)
//   bubble_cnt                      saturating count of interlock bubbles
`timescale 1ns/1ps

module decode_ex_stage_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_wr,
  input  logic             id_mem_to_reg,
  input  logic             wb_reg_wr,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_wr,
  output logic             ex_mem_to_reg,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned RW = 5;
  localparam int unsigned OW = 4;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
  logic [RW-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [OW-1:0]    alu_op_q, alu_op_d;
  logic             alu_src_q, alu_src_d, mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d, reg_wr_q, reg_wr_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             advance;
  logic [XLEN-1:0]  fwd_a, fwd_b;

  // Handshake and load-use hazard detection against the instruction in EX.
  always_comb begin
    advance        = !valid_q || ex_ready;
    load_use_stall = valid_q && mem_read_q && (rd_q != RW'(0)) && id_valid &&
                     ((id_rs1 == rd_q) || (id_rs2 == rd_q));
    id_ready       = advance && !load_use_stall;
  end

  // Operand bypass: x0 is hard zero, then write-back result, then register file.
  always_comb begin
    if (id_rs1 == RW'(0))                   fwd_a = '0;
    else if (wb_reg_wr && (wb_rd == id_rs1)) fwd_a = wb_data;
    else                                     fwd_a = id_rd1;
    if (id_rs2 == RW'(0))                   fwd_b = '0;
    else if (wb_reg_wr && (wb_rd == id_rs2)) fwd_b = wb_data;
    else                                     fwd_b = id_rd2;
  end

  // Next-state selection: flush > bubble > load > drain > hold-with-refresh.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_wr_d     = reg_wr_q;
    mem_to_reg_d = mem_to_reg_q;
    cnt_d        = cnt_q;

    if (flush || (advance && (load_use_stall || !id_valid))) begin
      valid_d      = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_wr_d     = 1'b0;
      mem_to_reg_d = 1'b0;
      if (!flush && load_use_stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (advance) begin
      valid_d      = 1'b1;
      pc_d         = id_pc;
      op_a_d       = fwd_a;
      op_b_d       = fwd_b;
      imm_d        = id_imm;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      rd_d         = id_rd;
      alu_op_d     = id_alu_op;
      alu_src_d    = id_alu_src;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      reg_wr_d     = id_reg_wr;
      mem_to_reg_d = id_mem_to_reg;
    end else begin
      // Held in EX: pick up a write-back that lands on a held source register.
      if (wb_reg_wr && (wb_rd != RW'(0)) && (wb_rd == rs1_q)) op_a_d = wb_data;
      if (wb_reg_wr && (wb_rd != RW'(0)) && (wb_rd == rs2_q)) op_b_d = wb_data;
    end
  end

  // Stage state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_wr_q     <= reg_wr_d;
      mem_to_reg_q <= mem_to_reg_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_op_a       = op_a_q;
  assign ex_op_b       = op_b_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_wr     = reg_wr_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_ex_stage_reg.sv
// Self-checking bench for decode_ex_stage_reg: directed scenarios plus random
// traffic, all compared against a behavioural model of the stage.
// The counter width is reduced so saturation is reachable in a short run.
`timescale 1ns/1ps

module tb_decode_ex_stage_reg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 8;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc, op_a, op_b, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu_op;
    logic            alu_src, mr, mw, rw, m2r;
    logic [CW-1:0]   cnt;
  } st_t;

  logic clk, n_rst;
  logic id_valid, id_ready;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0]  id_alu_op;
  logic id_alu_src, id_mem_read, id_mem_write, id_reg_wr, id_mem_to_reg;
  logic wb_reg_wr, ex_ready, flush;
  logic ex_valid;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_wr, ex_mem_to_reg;
  logic load_use_stall;
  logic [CW-1:0] bubble_cnt;

  st_t dut_s;
  st_t m;
  int  total = 0;
  int  bad   = 0;

  decode_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg), .wb_reg_wr(wb_reg_wr),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  assign dut_s = {ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_wr,
                  ex_mem_to_reg, bubble_cnt};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Architectural value of register r as seen by an instruction reading it now.
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (wb_reg_wr && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic logic model_stall();
    return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
           (id_rs1 == m.rd || id_rs2 == m.rd);
  endfunction

  function automatic logic model_ready();
    return (!m.valid || ex_ready) && !model_stall();
  endfunction

  function automatic st_t model_next();
    st_t n;
    logic room, kill;
    int  c;
    n = m;
    if (!n_rst) return '0;
    room = !m.valid || ex_ready;
    kill = flush || (room && (model_stall() || !id_valid));
    if (!flush && room && model_stall()) begin
      c = int'(m.cnt) + 1;
      if (c > (1 << CW) - 1) c = (1 << CW) - 1;
      n.cnt = CW'(c);
    end
    if (kill) begin
      n.valid = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.rw = 1'b0; n.m2r = 1'b0;
    end else if (room) begin
      n.valid = 1'b1; n.pc = id_pc; n.imm = id_imm;
      n.op_a = reg_value(id_rs1, id_rd1);
      n.op_b = reg_value(id_rs2, id_rd2);
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.alu_op = id_alu_op;
      n.alu_src = id_alu_src; n.mr = id_mem_read; n.mw = id_mem_write;
      n.rw = id_reg_wr; n.m2r = id_mem_to_reg;
    end else begin
      n.op_a = reg_value(m.rs1, m.op_a);
      n.op_b = reg_value(m.rs2, m.op_b);
    end
    return n;
  endfunction

  // Advance one clock; model follows the inputs present at the edge.
  task automatic tick();
    st_t nx;
    nx = model_next();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0;
    id_rd2 = 0; id_imm = 0; id_alu_op = 0; id_alu_src = 0; id_mem_read = 0;
    id_mem_write = 0; id_reg_wr = 0; id_mem_to_reg = 0; wb_reg_wr = 0;
    wb_rd = 0; wb_data = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = d1; id_rd2 = d2; id_imm = pc ^ 32'h5a5a; id_alu_op = 4'd0;
    id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_reg_wr = 1; id_mem_to_reg = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 0; idle(); m = '0;
    tick(); tick();
    n_rst = 1;
    set_alu(32'h100, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    tick(); tick();
    total++;
    if (ex_valid !== 1'b1) begin bad++; $display("FAIL reset_prefill: ex_valid=%b want 1", ex_valid); end
    #2 n_rst = 0; m = '0;
    #1;
    total++;
    if (dut_s !== '0) begin bad++; $display("FAIL reset_clear: got %h want 0", dut_s); end
    tick();
    #2 n_rst = 1; idle();
    #1;
    total++;
    if (id_ready !== 1'b1 || load_use_stall !== 1'b0) begin
      bad++; $display("FAIL reset_ready: id_ready=%b stall=%b want 1/0", id_ready, load_use_stall);
    end
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      set_alu(32'h1000 + 32'(i * 4), 5'd5, 5'd6, 5'd10, 32'h10, 32'h20);
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_op_a !== 32'h10 || ex_op_b !== 32'h20 ||
          ex_pc !== 32'h1000 + 32'(i * 4)) begin
        bad++; $display("FAIL stream_%0d: v=%b a=%h b=%h pc=%h want 1/10/20/%h", i, ex_valid,
                        ex_op_a, ex_op_b, ex_pc, 32'h1000 + 32'(i * 4));
      end
      total++;
      if (dut_s !== m) begin bad++; $display("FAIL stream_model_%0d: got %h want %h", i, dut_s, m); end
    end
    idle(); tick();
  endtask

  task automatic test_bypass();
    set_alu(32'h2000, 5'd7, 5'd0, 5'd1, 32'h1111, 32'h0);
    wb_reg_wr = 1; wb_rd = 5'd7; wb_data = 32'hABCD;
    tick();
    total++;
    if (ex_op_a !== 32'hABCD) begin bad++; $display("FAIL bypass_x7: got %h want abcd", ex_op_a); end
    set_alu(32'h2004, 5'd0, 5'd0, 5'd1, 32'h1111, 32'h2222);
    wb_reg_wr = 1; wb_rd = 5'd0; wb_data = 32'hABCD;
    tick();
    total++;
    if (ex_op_a !== 32'h0 || ex_op_b !== 32'h0) begin
      bad++; $display("FAIL bypass_x0: a=%h b=%h want 0/0", ex_op_a, ex_op_b);
    end
    // both sources hit the write-back register
    set_alu(32'h2008, 5'd12, 5'd12, 5'd1, 32'h1, 32'h2);
    wb_reg_wr = 1; wb_rd = 5'd12; wb_data = 32'h7777;
    tick();
    total++;
    if (ex_op_a !== 32'h7777 || ex_op_b !== 32'h7777) begin
      bad++; $display("FAIL bypass_both: a=%h b=%h want 7777/7777", ex_op_a, ex_op_b);
    end
    idle(); tick();
  endtask

  task automatic test_load_use();
    logic [CW-1:0] c0;
    for (int k = 0; k < 2; k++) begin
      set_alu(32'h3000, 5'd1, 5'd0, (k == 0) ? 5'd9 : 5'd0, 32'h4, 32'h0);
      id_mem_read = 1; id_mem_to_reg = 1;
      tick();
      c0 = bubble_cnt;
      set_alu(32'h3004, 5'd2, (k == 0) ? 5'd9 : 5'd0, 5'd4, 32'h8, 32'h9);
      #1;
      total++;
      if (load_use_stall !== (k == 0) || id_ready !== (k != 0)) begin
        bad++; $display("FAIL loaduse_detect_%0d: stall=%b ready=%b want %b/%b", k,
                        load_use_stall, id_ready, k == 0, k != 0);
      end
      tick();
      total++;
      if (k == 0 && (ex_valid !== 1'b0 || bubble_cnt !== c0 + CW'(1))) begin
        bad++; $display("FAIL loaduse_bubble: v=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0 + CW'(1));
      end else if (k == 1 && (ex_valid !== 1'b1 || ex_pc !== 32'h3004 || bubble_cnt !== c0)) begin
        bad++; $display("FAIL loaduse_x0: v=%b pc=%h cnt=%0d want 1/3004/%0d", ex_valid, ex_pc, bubble_cnt, c0);
      end
      if (k == 0) begin
        tick();
        total++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h3004 || ex_rs2 !== 5'd9) begin
          bad++; $display("FAIL loaduse_enter: v=%b pc=%h rs2=%0d want 1/3004/9", ex_valid, ex_pc, ex_rs2);
        end
      end
      total++;
      if (dut_s !== m) begin bad++; $display("FAIL loaduse_model_%0d: got %h want %h", k, dut_s, m); end
      idle(); tick();
    end
  endtask

  task automatic test_backpressure();
    set_alu(32'h200, 5'd3, 5'd4, 5'd5, 32'h30, 32'h40);
    tick();
    set_alu(32'h204, 5'd1, 5'd2, 5'd6, 32'h1, 32'h2);
    ex_ready = 0;
    for (int c = 0; c < 4; c++) begin
      wb_reg_wr = (c == 1); wb_rd = 5'd3; wb_data = 32'h55;
      #1;
      total++;
      if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d: got %b want 0", c, id_ready); end
      tick();
      total++;
      if (ex_pc !== 32'h200 || ex_op_a !== ((c >= 1) ? 32'h55 : 32'h30) || ex_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold_%0d: pc=%h a=%h v=%b want 200/%h/1", c, ex_pc, ex_op_a, ex_valid,
                        (c >= 1) ? 32'h55 : 32'h30);
      end
    end
    ex_ready = 1; wb_reg_wr = 0;
    tick();
    total++;
    if (ex_pc !== 32'h204 || dut_s !== m) begin
      bad++; $display("FAIL bp_release: pc=%h want 204, got %h want %h", ex_pc, dut_s, m);
    end
    idle(); tick();
  endtask

  task automatic test_flush();
    logic [CW-1:0] c0;
    set_alu(32'h400, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0);
    id_mem_read = 1; id_mem_to_reg = 1; id_mem_write = 1;
    tick();
    c0 = bubble_cnt;
    set_alu(32'h404, 5'd9, 5'd9, 5'd4, 32'h0, 32'h0);
    flush = 1;
    tick();
    total++;
    if (ex_valid !== 1'b0 || ex_reg_wr !== 1'b0 || ex_mem_write !== 1'b0 || bubble_cnt !== c0) begin
      bad++; $display("FAIL flush: v=%b rw=%b mw=%b cnt=%0d want 0/0/0/%0d",
                      ex_valid, ex_reg_wr, ex_mem_write, bubble_cnt, c0);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0); id_pc = $urandom;
      id_rs1 = 5'($urandom_range(0, 6)); id_rs2 = 5'($urandom_range(0, 6));
      id_rd = 5'($urandom_range(0, 6)); id_rd1 = $urandom; id_rd2 = $urandom;
      id_imm = $urandom; id_alu_op = 4'($urandom); id_alu_src = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      id_reg_wr = 1'($urandom); id_mem_to_reg = 1'($urandom);
      wb_reg_wr = 1'($urandom); wb_rd = 5'($urandom_range(0, 6)); wb_data = $urandom;
      ex_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (id_ready !== model_ready() || load_use_stall !== model_stall()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_comb_%0d: ready=%b stall=%b want %b/%b", i,
                                id_ready, load_use_stall, model_ready(), model_stall());
      end
      tick();
      total++;
      if (dut_s !== m) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_state_%0d: got %h want %h", i, dut_s, m);
      end
    end
    idle(); tick();
  endtask

  task automatic test_saturation();
    int ilk, cyc;
    ilk = 0; cyc = 0;
    set_alu(32'h500, 5'd9, 5'd1, 5'd9, 32'h0, 32'h0);
    id_mem_read = 1;
    while (ilk < (1 << CW) + 2 && cyc < 8 * ((1 << CW) + 2)) begin
      if (model_stall() && (!m.valid || ex_ready)) ilk++;
      tick();
      cyc++;
    end
    total++;
    if (ilk < (1 << CW) + 2) begin bad++; $display("FAIL sat_timeout: interlocks=%0d", ilk); end
    total++;
    if (bubble_cnt !== {CW{1'b1}} || dut_s !== m) begin
      bad++; $display("FAIL saturation: cnt=%h want %h", bubble_cnt, {CW{1'b1}});
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ex_stage_reg.md
Name: decode_ex_stage_reg

Overview:
ID/EX pipeline stage register of the RV32I core, directly downstream of the decode register file. It consumes rd1/rd2 plus decoded control from the decode stage and presents registered operands and control to the execute stage. It also provides:
- write-back bypass around the register file's write-then-read gap;
- load-use interlock (one bubble);
- valid/ready back-pressure with operand refresh while held;
- flush;
- saturating bubble counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
n_rst  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_ready  out  1  stage accepts decode instruction this cycle
id_pc  in  XLEN  PC of decode instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rd1, id_rd2  in  XLEN  register file read data
id_imm  in  XLEN  decoded immediate
id_alu_op  in  4  ALU operation code
id_alu_src, id_mem_read, id_mem_write, id_reg_wr, id_mem_to_reg  in  1 each  control bits
wb_reg_wr  in  1  write-back writes register file this cycle
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back data
ex_ready  in  1  execute stage consumes ex_* this cycle
flush  in  1  kill contents (branch/jump redirect)
ex_valid  out  1  ex_* holds a valid instruction
ex_pc, ex_op_a, ex_op_b, ex_imm  out  XLEN each  registered PC, rs1 data, rs2 data, immediate
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
ex_alu_op  out  4  registered ALU op
ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_wr, ex_mem_to_reg  out  1 each  registered control
load_use_stall  out  1  interlock active (combinational)
bubble_cnt  out  CNT_W  count of interlock bubbles inserted

Behaviour:
- Reset (n_rst low, asynchronous): every ex_* output and bubble_cnt = 0. id_ready then evaluates to 1 and load_use_stall to 0 combinationally. Reset mid-transfer drops the instruction.
- Stage is a single-entry buffer. Conditions:
  - advance = !ex_valid || ex_ready
  - load_use_stall = ex_valid && ex_mem_read && ex_rd != 0 && id_valid && (id_rs1 == ex_rd || id_rs2 == ex_rd)
  - id_ready = advance && !load_use_stall
- Bypass operand selection, applied to each of rs1/rs2 independently:
  - index == 0 → 0;
  - else wb_reg_wr && wb_rd == index → wb_data;
  - else id_rd1 / id_rd2.
- Per-cycle priority, highest first:
  1. flush: ex_valid <= 0; all control bits (mem_read, mem_write, reg_wr, mem_to_reg) <= 0; datapath fields may hold. bubble_cnt not incremented.
  2. advance && load_use_stall: insert bubble. ex_valid <= 0; control bits <= 0; bubble_cnt increments, saturating at all-ones.
  3. advance && id_valid: load all ex_* from id_*, operands via bypass; ex_valid <= 1.
  4. advance && !id_valid: ex_valid <= 0; control bits <= 0.
  5. Hold (ex_valid && !ex_ready): all fields keep value, with operand refresh. If wb_reg_wr && wb_rd != 0 && wb_rd == ex_rs1, ex_op_a <= wb_data. Same rule for ex_rs2 / ex_op_b.
- Latency: one cycle from id handshake (id_valid && id_ready) to ex_valid.
- Throughput: one instruction per cycle when ex_ready stays high.
- Interlock lasts exactly one cycle: once the bubble enters, ex_mem_read = 0, so the condition clears.
- A load held in EX by !ex_ready keeps load_use_stall asserted but inserts no bubble (advance = 0).
- x0 never bypassed or refreshed; ex_op_a/b for index 0 is always 0.
- Both operands equal to wb_rd: both receive wb_data in the same cycle.

Test Plan:
- Reset: assert n_rst=0 mid-stream with ex_valid=1 → all ex_* = 0, bubble_cnt = 0; after release, id_ready = 1.
- Streaming: 3 back-to-back ADDs with ex_ready=1, rs1=x5 (rd1=0x10), rs2=x6 (rd2=0x20) → each appears one cycle later with ex_op_a=0x10, ex_op_b=0x20, ex_valid=1.
- WB bypass:
  - id_rs1=x7, id_rd1=0x1111, wb_reg_wr=1, wb_rd=7, wb_data=0xABCD → ex_op_a=0xABCD.
  - Same with id_rs1=x0, wb_rd=0 → ex_op_a=0.
- Load-use:
  - LW x9 in EX, id_rs2=x9 → load_use_stall=1, id_ready=0; next cycle ex_valid=0, bubble_cnt=1; following cycle the dependent instruction enters.
  - Same with LW rd=x0 → no stall.
- Back-pressure: ex_ready=0 for 4 cycles with ex_rs1=x3 held; in cycle 2 wb_rd=3, wb_data=0x55 → ex_op_a=0x55; ex_pc unchanged; id_ready=0 throughout.
- Flush: flush=1 together with a load-use condition and id_valid=1 → next cycle ex_valid=0, ex_reg_wr=0, ex_mem_write=0; bubble_cnt unchanged.
- Saturation: force 2^CNT_W+2 interlocks → bubble_cnt stays 0xFFFF.
